// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, writeback mux, register-file write port and sticky halt.
// Define RETIRE_CNT_EN to build the 16-bit retired-instruction counter.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [15:0] mem_aluResult,
    input  logic [15:0] mem_readData,
    input  logic [15:0] mem_pcPlus2,
    input  logic [15:0] mem_imm,
    input  logic [1:0]  mem_wbSel,
    input  logic        mem_regWrite,
    input  logic [2:0]  mem_writeReg,
    input  logic        mem_halt,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] wbData,
    output logic [2:0]  wbReg,
    output logic        wbEn,
    output logic        fwdValid,
    output logic        halted,
    output logic [15:0] retired
);

    typedef struct packed {
        logic        valid;
        logic [1:0]  wbSel;
        logic        regWrite;
        logic [2:0]  writeReg;
        logic        halt;
        logic [15:0] aluResult;
        logic [15:0] readData;
        logic [15:0] pcPlus2;
        logic [15:0] imm;
        logic        done;
    } mw_t;

    mw_t  mw_q, mw_d;
    logic halted_q, halted_d;

    // done marks an instruction that already wrote back, so a stall never repeats the write.
    always_comb begin
        mw_d = mw_q;
        if (!halted_q) begin
            if (flush) begin
                mw_d.valid = 1'b0;
            end else if (stall) begin
                mw_d.done = mw_q.done | mw_q.valid;
            end else begin
                mw_d.valid     = mem_valid;
                mw_d.wbSel     = mem_wbSel;
                mw_d.regWrite  = mem_regWrite;
                mw_d.writeReg  = mem_writeReg;
                mw_d.halt      = mem_halt;
                mw_d.aluResult = mem_aluResult;
                mw_d.readData  = mem_readData;
                mw_d.pcPlus2   = mem_pcPlus2;
                mw_d.imm       = mem_imm;
                mw_d.done      = 1'b0;
            end
        end
    end

    assign halted_d = halted_q | (mw_q.valid & mw_q.halt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mw_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            mw_q     <= mw_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        wbData = mw_q.aluResult;
        case (mw_q.wbSel)
            2'b01:   wbData = mw_q.readData;
            2'b10:   wbData = mw_q.pcPlus2;
            2'b11:   wbData = mw_q.imm;
            default: wbData = mw_q.aluResult;
        endcase
    end

    assign wbReg    = mw_q.writeReg;
    // A HALT occupies WB like any instruction but must not touch the register file.
    assign wbEn     = mw_q.valid & mw_q.regWrite & ~mw_q.done & ~halted_q & ~mw_q.halt;
    assign fwdValid = mw_q.valid & mw_q.regWrite & ~halted_q;
    assign halted   = halted_q;

`ifdef RETIRE_CNT_EN
    logic [15:0] retired_q, retired_d;
    logic        retire;

    assign retire    = mw_q.valid & ~mw_q.done & ~halted_q;
    assign retired_d = retired_q + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         retired_q <= 16'h0000;
        else if (retire) retired_q <= retired_d;
    end

    assign retired = retired_q;
`else
    assign retired = 16'h0000;
`endif

endmodule
